// File: rtl/rf_pkg.sv
// rf_pkg: shared types and constants for the register-file writeback arbiter
package rf_pkg;
    localparam int XLEN = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // valid = 0 marks an entry killed by a younger ALU write; it still holds its slot
    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: ordered buffer of pending load results with kill-by-rd and rd-match lookup
// Ports: push/push_entry enqueue at tail; pop dequeues head; kill_en/kill_rd invalidate
// every entry with that rd; match_a/match_b return per-entry hits in age order
// (bit 0 = oldest); head/count expose the head entry and occupancy.
// With RF_WB_FWD_EN defined, age_data exposes entry data in the same age order.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  wb_entry_t               push_entry,
    input  logic                    pop,
    input  logic                    kill_en,
    input  logic [4:0]              kill_rd,
    input  logic [4:0]              match_a,
    input  logic [4:0]              match_b,
    output wb_entry_t               head,
    output logic [$clog2(DEPTH):0]  count,
    output logic [DEPTH-1:0]        hit_a,
    output logic [DEPTH-1:0]        hit_b
`ifdef RF_WB_FWD_EN
    ,
    output logic [DEPTH-1:0][XLEN-1:0] age_data
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t      mem [DEPTH];
    wb_entry_t      slot;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (kill_en && mem[i].valid && mem[i].rd == kill_rd) mem[i].valid <= 1'b0;
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            // clearing valid on pop keeps unoccupied slots from ever matching
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        hit_a = '0;
        hit_b = '0;
        slot  = '0;
`ifdef RF_WB_FWD_EN
        age_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            slot     = mem[rd_ptr + AW'(i)];
            hit_a[i] = slot.valid && slot.rd == match_a;
            hit_b[i] = slot.valid && slot.rd == match_b;
`ifdef RF_WB_FWD_EN
            age_data[i] = slot.data;
`endif
        end
    end
endmodule

// File: rtl/rf_wb_arb.sv
// rf_wb_arb: merges ALU writeback and LSU load returns onto the single register-file write port
// Ports: alu_we/alu_rd/alu_wdata ALU writeback (highest priority); lsu_valid/lsu_ready/
// lsu_rd/lsu_wdata load-return handshake; rf_we/rf_rd/rf_wdata register-file write port;
// rs1/rs2 decode sources with hz1/hz2 hazards and fwd1/fwd2 forwarded load data;
// alu_hold asks the pipeline to drop its ALU write next cycle so a starved head can drain.
// Build option RF_WB_FWD_EN: forward buffered load data instead of raising hazards.
module rf_wb_arb
    import rf_pkg::*;
#(
    parameter int LSU_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_we,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_wdata,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        hz1,
    output logic        hz2,
    output logic        fwd1_valid,
    output logic        fwd2_valid,
    output logic [31:0] fwd1_data,
    output logic [31:0] fwd2_data,
    output logic        alu_hold
);
    localparam int CW = $clog2(LSU_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    wb_entry_t              head;
    wb_entry_t              push_entry;
    logic [CW-1:0]          count;
    logic [LSU_DEPTH-1:0]   m1;
    logic [LSU_DEPTH-1:0]   m2;
    logic [SW-1:0]          starve;
    logic                   alu_w, empty, xfer, pop, bypass, drop, push, hit1, hit2;

    assign alu_w      = alu_we && alu_rd != REG_ZERO;
    assign empty      = count == '0;
    assign lsu_ready  = count != CW'(LSU_DEPTH);
    assign xfer       = lsu_valid && lsu_ready;
    assign pop        = !alu_w && !empty;
    // no bypass during reset so rf_we follows alu_we alone
    assign bypass     = !alu_w && empty && xfer && rst_n;
    // x0 loads and loads overtaken by a same-cycle ALU write to the same rd are discarded
    assign drop       = lsu_rd == REG_ZERO || (alu_w && lsu_rd == alu_rd);
    assign push       = xfer && !bypass && !drop;
    assign push_entry = '{valid: 1'b1, rd: lsu_rd, data: lsu_wdata};

    assign rf_we    = alu_w || (pop && head.valid) || (bypass && lsu_rd != REG_ZERO);
    assign rf_rd    = alu_w ? alu_rd : pop ? head.rd : lsu_rd;
    assign rf_wdata = alu_w ? alu_wdata : pop ? head.data : lsu_wdata;

    assign alu_hold = starve >= SW'(STARVE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve <= '0;
        else if (empty || pop) starve <= '0;
        else if (!alu_hold) starve <= starve + 1'b1;
    end

`ifdef RF_WB_FWD_EN
    logic [LSU_DEPTH-1:0][XLEN-1:0] age_data;
`endif

    rf_wb_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (alu_w),
        .kill_rd    (alu_rd),
        .match_a    (rs1),
        .match_b    (rs2),
        .head       (head),
        .count      (count),
        .hit_a      (m1),
        .hit_b      (m2)
`ifdef RF_WB_FWD_EN
        ,
        .age_data   (age_data)
`endif
    );

    assign hit1 = rs1 != REG_ZERO && |m1;
    assign hit2 = rs2 != REG_ZERO && |m2;

`ifdef RF_WB_FWD_EN
    // later (younger) matches override older ones
    always_comb begin
        fwd1_data = '0;
        fwd2_data = '0;
        for (int i = 0; i < LSU_DEPTH; i++) begin
            if (m1[i] && rs1 != REG_ZERO) fwd1_data = age_data[i];
            if (m2[i] && rs2 != REG_ZERO) fwd2_data = age_data[i];
        end
    end
    assign fwd1_valid = hit1;
    assign fwd2_valid = hit2;
    assign hz1        = 1'b0;
    assign hz2        = 1'b0;
`else
    assign hz1        = hit1;
    assign hz2        = hit2;
    assign fwd1_valid = 1'b0;
    assign fwd2_valid = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_data  = '0;
`endif
endmodule

// File: tb/tb_rf_wb_arb.sv
// tb_rf_wb_arb: randomized and directed checks of rf_wb_arb against a queue-based model
module tb_rf_wb_arb;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_we = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_wdata = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_wdata = '0;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        hz1, hz2, fwd1_valid, fwd2_valid, alu_hold;
    logic [31:0] fwd1_data, fwd2_data;

    rf_wb_arb #(.LSU_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_we(alu_we), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .rs1(rs1), .rs2(rs2), .hz1(hz1), .hz2(hz2),
        .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .alu_hold(alu_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    int          starve = 0;
    int          n_pass = 0;
    int          n_chk = 0;
    bit          last_xfer;
    int          sent;
    logic [31:0] dut_rf [32] = '{default: 32'h0};

    always @(posedge clk) if (rf_we) dut_rf[rf_rd] <= rf_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic hz_chk(input string tag, input logic [4:0] r, input logic hz, input logic fv,
                          input logic [31:0] fd);
        bit          h = 0;
        logic [31:0] f = '0;
        foreach (q[i]) if (q[i].v && r != 0 && q[i].rd == r) begin h = 1; f = q[i].d; end
`ifdef RF_WB_FWD_EN
        chk({tag, "_fwd_valid"}, fv, h);
        chk({tag, "_fwd_data"}, fd, f);
        chk({tag, "_hz"}, hz, 0);
`else
        chk({tag, "_hz"}, hz, h);
        chk({tag, "_fwd_valid"}, fv, 0);
        chk({tag, "_fwd_data"}, fd, 0);
`endif
    endtask

    // drive one cycle, compare combinational outputs mid-cycle, then advance the model
    task automatic step(input logic aw, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic [4:0] r1, input logic [4:0] r2);
        bit          alu_w, xfer, popq, byp, e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_d;
        alu_we = aw; alu_rd = ard; alu_wdata = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_wdata = ld;
        rs1 = r1; rs2 = r2;
        @(negedge clk);
        alu_w = aw && ard != 0;
        xfer  = lv && q.size() < DEPTH;
        popq  = !alu_w && q.size() > 0;
        byp   = !alu_w && q.size() == 0 && xfer;
        e_we  = alu_w ? 1'b1 : popq ? q[0].v : byp ? (lrd != 0) : 1'b0;
        e_rd  = alu_w ? ard : popq ? q[0].rd : lrd;
        e_d   = alu_w ? ad : popq ? q[0].d : ld;
        chk("lsu_ready", lsu_ready, q.size() < DEPTH);
        chk("alu_hold", alu_hold, starve >= SMAX);
        chk("rf_we", rf_we, e_we);
        if (e_we) begin
            chk("rf_rd", rf_rd, e_rd);
            chk("rf_wdata", rf_wdata, e_d);
        end
        hz_chk("src1", r1, hz1, fwd1_valid, fwd1_data);
        hz_chk("src2", r2, hz2, fwd2_valid, fwd2_data);
        last_xfer = xfer;
        starve = (q.size() > 0 && !popq) ? (starve < SMAX ? starve + 1 : starve) : 0;
        if (popq) void'(q.pop_front());
        if (alu_w) foreach (q[i]) if (q[i].rd == ard) q[i].v = 0;
        if (xfer && !byp && lrd != 0 && !(alu_w && lrd == ard))
            q.push_back('{v: 1'b1, rd: lrd, d: ld});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_lsu_ready", lsu_ready, 1);
        chk("rst_alu_hold", alu_hold, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_hz1", hz1, 0);
        chk("rst_fwd1_valid", fwd1_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // solo ALU write and x0 write
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("solo_x5", dut_rf[5], 32'hDEADBEEF);
        step(1, 0, 32'h12345678, 0, 0, 0, 0, 0);
        chk("x0_untouched", dut_rf[0], 0);

        // collision: ALU wins, load lands the next cycle, hazard visible meanwhile
        step(1, 3, 32'hAAAA0003, 1, 4, 32'h11, 4, 0);
        chk("coll_x3", dut_rf[3], 32'hAAAA0003);
        step(0, 0, 0, 0, 0, 0, 4, 4);
        chk("coll_x4", dut_rf[4], 32'h11);

        // fill with ALU continuously writing until the arbiter asks for a bubble
        sent = 0;
        for (int c = 0; c < 20 && starve < SMAX; c++) begin
            step(1, 1, 32'(c), sent < 3, 5'(2 + sent), 32'h100 + 32'(sent), 2, 3);
            if (last_xfer) sent++;
        end
        chk("fill_hold", alu_hold, 1);
        chk("fill_full", lsu_ready, 0);
        for (int c = 0; c < 10 && (q.size() > 0 || sent < 3); c++) begin
            step(0, 0, 0, sent < 3, 5'(2 + sent), 32'h100 + 32'(sent), 3, 4);
            if (last_xfer) sent++;
        end
        chk("fill_x2", dut_rf[2], 32'h100);
        chk("fill_x3", dut_rf[3], 32'h101);
        chk("fill_x4", dut_rf[4], 32'h102);

        // WAW: buffered load to x7 killed by a younger ALU write
        step(1, 1, 0, 1, 7, 32'h55, 7, 0);
        step(1, 7, 32'h22, 0, 0, 0, 7, 0);
        step(0, 0, 0, 0, 0, 0, 7, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("waw_x7", dut_rf[7], 32'h22);

        // reset with two buffered loads
        step(1, 1, 0, 1, 10, 32'hA0, 0, 0);
        step(1, 1, 0, 1, 11, 32'hB0, 10, 11);
        alu_we = 0; lsu_valid = 1; lsu_rd = 12; lsu_wdata = 32'hC0; rs1 = 10; rs2 = 11;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", lsu_ready, 1);
        chk("mid_rst_hz1", hz1, 0);
        chk("mid_rst_hz2", hz2, 0);
        chk("mid_rst_fwd1", fwd1_valid, 0);
        chk("mid_rst_hold", alu_hold, 0);
        chk("mid_rst_we", rf_we, 0);
        alu_we = 1; alu_rd = 9;
        #1;
        chk("mid_rst_alu_we", rf_we, 1);
        alu_we = 0; lsu_valid = 0;
        q.delete();
        starve = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 0, 0, 10, 11);
        chk("rst_x10", dut_rf[10], 0);
        chk("rst_x11", dut_rf[11], 0);
        chk("rst_x12", dut_rf[12], 0);

        // randomized traffic; the pipeline honours alu_hold
        for (int c = 0; c < 400; c++)
            step((starve < SMAX) && ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rf_wb_arb.md
# rf_wb_arb

Write-port arbiter and sequencer for the core's 32x32 register file (single write port: `we`/`rd`/`wdata`, x0 hard-wired zero). It merges the in-order ALU writeback stream and the variable-latency LSU load-return stream onto that one port. ALU writes always take priority. Losing LSU results wait in a small ordered buffer that reports register hazards to decode. It sits between the execute/memory stages and the register file.

## Interface
- `LSU_DEPTH`, default 2: LSU buffer entries; power of two, at least 2.
- `STARVE_MAX`, default 4: cycles a buffered head entry may wait before the block requests an ALU bubble.
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `alu_we`  in  1  ALU writeback request
- `alu_rd`  in  5  ALU destination
- `alu_wdata`  in  32  ALU result
- `lsu_valid`  in  1  load result valid
- `lsu_ready`  out  1  buffer can accept a load result
- `lsu_rd`  in  5  load destination
- `lsu_wdata`  in  32  load data
- `rf_we`  out  1  to register-file `we`
- `rf_rd`  out  5  to register-file `rd`
- `rf_wdata`  out  32  to register-file `wdata`
- `rs1`, `rs2`  in  5 each  decode source registers
- `hz1`, `hz2`  out  1 each  source matches a pending buffered load
- `fwd1_valid`, `fwd2_valid`  out  1 each  forwarded data valid
- `fwd1_data`, `fwd2_data`  out  32 each  forwarded load data
- `alu_hold`  out  1  request that the pipeline suppress ALU writeback next cycle

## Operation
- LSU handshake: a transfer occurs when `lsu_valid && lsu_ready`. `lsu_ready = !full`, based on registered occupancy only. A pop does not raise `lsu_ready` in the same cycle.
- LSU results are always older than a concurrent ALU write.
- Port selection, in priority order each cycle:
  - If `alu_we && alu_rd != 0`: write the ALU result.
  - Else if the buffer is non-empty: pop the head and write it.
  - Else if an LSU transfer occurs: bypass it straight to the port, with no buffering.
  - Else: `rf_we = 0`.
- Buffering: an LSU transfer that is not bypassed is pushed at the tail.
- x0: `rd == 0` writes never drive `rf_we`.
  - ALU writes to x0 do not block the buffer.
  - LSU transfers to x0 complete the handshake and are discarded, not buffered.
- WAW kill: an ALU write to rd R invalidates every buffered entry with rd R. An LSU transfer to R in the same cycle is discarded.
  - Killed entries still occupy their slot and pop with `rf_we = 0`.
- Starvation counter:
  - Increments each cycle the buffer head is valid and not popped.
  - Clears on pop or when the buffer is empty.
  - `alu_hold = 1` while count is at least `STARVE_MAX`.
  - The pipeline must deassert `alu_we` the following cycle, so the head pops.
- Hazards: a source matches when `rsN != 0` and equals the rd of any valid, unkilled buffered entry. When several entries match, the youngest wins.

## Timing
- Port outputs (`rf_*`) are combinational from inputs and buffer head: ALU and bypass writes land in the register file at the same clock edge.
- A buffered entry can pop, at the earliest, in the cycle after its push.
- `hz*` and `fwd*` are combinational from `rs*` and registered buffer state.
- Reset (async, immediate):
  - Buffer empty, all entries invalid, counter 0.
  - `lsu_ready = 1`, `alu_hold = 0`.
  - `hz* = 0`, `fwd*_valid = 0`, `fwd*_data = 0`.
  - `rf_we` depends only on `alu_we` while reset is asserted.
- Reset mid-operation drops all buffered results with no register-file write.
- Full buffer with a simultaneous pop: `lsu_ready` stays 0 for that cycle.
- Pointer wrap: `$clog2(LSU_DEPTH)`-bit pointers plus a registered count. Full when count equals `LSU_DEPTH`.

## Configuration
- `RF_WB_FWD_EN` defined:
  - A matching source drives `fwd*_valid = 1` and `fwd*_data` with the youngest matching entry's data.
  - `hz*` is tied 0.
- `RF_WB_FWD_EN` undefined:
  - A match drives `hz* = 1`.
  - `fwd*_valid` and `fwd*_data` are tied 0.
  - No forwarding muxes are synthesised.

## Structure
- `rf_pkg` holds:
  - `REG_ZERO` (5'd0)
  - typedef `wb_entry_t` { `valid`, `rd[4:0]`, `data[31:0]` }
  - `XLEN = 32`
- Sub-module `rf_wb_fifo`: ordered buffer of `wb_entry_t` with push/pop, a per-entry kill-by-rd port, and parallel rd-match outputs. Arbitration, the starvation counter and hazard/forward logic stay in `rf_wb_arb`.

## Test plan
- Solo ALU write of x5=0xDEADBEEF: `rf_we = 1`, `rf_rd = 5` in the same cycle.
- ALU write to x0: `rf_we = 0`.
- Collision: ALU x3 and LSU x4=0x11 in the same cycle. ALU written that cycle; x4=0x11 written the next cycle. With `rs1 = 4` in between, `hz1 = 1`, or with `RF_WB_FWD_EN` set, `fwd1_data = 0x11`.
- Fill: `alu_we` held high with 3 LSU results at `LSU_DEPTH = 2`. `lsu_ready = 0` after 2 pushes. `alu_hold = 1` after 4 stalled cycles; after the bubble the head pops.
- WAW: buffered LSU x7 followed by ALU write x7=0x22. The entry is killed, its later pop has `rf_we = 0`, and x7 stays 0x22.
- Reset asserted with 2 entries buffered: `lsu_ready = 1`, `hz* = 0` immediately, and no later writes occur.
